// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS decode stage and its sub-blocks.
//   - opcode constants for every instruction class the decoder understands
//   - REG_ZERO, the hard-wired zero register index
//   - ext_kind_e, the immediate extension kinds
//   - id_ex_t, the fixed-width control/pass-through part of the ID/EX register
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SIGN,
        ZERO,
        UPPER
    } ext_kind_e;

    // Only the fields whose width does not depend on DATA_W/REG_NUM live
    // here; operand, immediate and register-index fields are parameterised
    // and are kept as separate registers in the stage itself.
    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [25:0] jpc;
        logic [31:0] npc;
    } id_ex_t;

endpackage

// File: rtl/regfile.sv
// regfile: architectural register file with write-back bypass.
//   clk, rst_n            clock and asynchronous active-low reset (clears all registers)
//   rd_idx_a, rd_idx_b    read indices
//   rd_data_a, rd_data_b  read data; register 0 reads 0, a same-cycle WB write is forwarded
//   wb_we, wb_reg, wb_data  write port; writes to register 0 are ignored
module regfile
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_idx_a,
    input  logic [REG_AW-1:0] rd_idx_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic              wr_en;

    assign wr_en = wb_we && (wb_reg != REG_AW'(REG_ZERO));

    // Storage: the whole array is cleared on reset so a fresh pipeline
    // never sees X operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_reg] <= wb_data;
        end
    end

    // Read ports: the WB value is forwarded so an instruction decoded in the
    // same cycle as the write-back sees the new value without an extra stall.
    always_comb begin
        rd_data_a = regs[rd_idx_a];
        if (rd_idx_a == REG_AW'(REG_ZERO)) begin
            rd_data_a = '0;
        end else if (wr_en && (wb_reg == rd_idx_a)) begin
            rd_data_a = wb_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_idx_b];
        if (rd_idx_b == REG_AW'(REG_ZERO)) begin
            rd_data_b = '0;
        end else if (wr_en && (wb_reg == rd_idx_b)) begin
            rd_data_b = wb_data;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage between IF/ID and EX.
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       handshake with IF/ID; ins and npc_i are the offered instruction
//   flush                   kills the instruction in ID and empties ID/EX
//   wb_we/wb_reg/wb_data    register file write-back port
//   ex_ready                EX accepts the ID/EX contents
//   out_*                   registered ID/EX contents (controls, indices, operands, immediate)
// Load-use hazards against the instruction sitting in ID/EX are resolved by
// stalling one bubble; operands of a held ID/EX entry are refreshed from WB.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int REG_AW   = $clog2(REG_NUM),
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ins,
    input  logic [31:0]       npc_i,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_illegal,
    output logic [5:0]        out_op,
    output logic [5:0]        out_func,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_wr_reg,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [25:0]       out_jpc,
    output logic [31:0]       out_npc
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rt_idx;
    logic [REG_AW-1:0] rd_idx;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    id_ex_t            dec_ctrl;
    logic [REG_AW-1:0] dec_wr_reg;
    ext_kind_e         dec_ext;
    logic [DATA_W-1:0] dec_imm;

    id_ex_t            ctrl_q;
    logic              advance;
    logic              hazard;
    logic              capture;
    logic              wb_hit;

    assign op     = ins[31:26];
    assign rs_idx = REG_AW'(ins[25:21]);
    assign rt_idx = REG_AW'(ins[20:16]);
    assign rd_idx = REG_AW'(ins[15:11]);
    assign imm16  = ins[15:0];

    regfile #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .REG_AW  (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_a  (rs_idx),
        .rd_idx_b  (rt_idx),
        .rd_data_a (rs_data),
        .rd_data_b (rt_data),
        .wb_we     (wb_we),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data)
    );

    // Control decode: every class starts from "no side effects" and only
    // turns on what it needs; unknown opcodes keep all controls off.
    always_comb begin
        dec_ctrl           = '0;
        dec_ctrl.op        = op;
        dec_ctrl.func      = ins[5:0];
        dec_ctrl.jpc       = ins[25:0];
        dec_ctrl.npc       = npc_i;
        dec_wr_reg         = '0;
        dec_ext            = SIGN;
        case (op)
            OP_SPECIAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = rd_idx;
            end
            OP_ADDI, OP_ADDIU: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = rt_idx;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = rt_idx;
                dec_ext            = ZERO;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = rt_idx;
                dec_ext            = UPPER;
            end
            OP_LW, OP_LB: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_wr_reg         = rt_idx;
            end
            OP_SW, OP_SB: begin
                dec_ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGTZ, OP_J: begin
            end
            OP_JAL: begin
                dec_ctrl.reg_write = 1'b1;
                dec_wr_reg         = REG_AW'(LINK_REG);
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // Immediate extension by kind.
    always_comb begin
        dec_imm = {{(DATA_W-16){imm16[15]}}, imm16};
        case (dec_ext)
            ZERO:    dec_imm = DATA_W'(imm16);
            UPPER:   dec_imm = DATA_W'({imm16, 16'h0000});
            default: dec_imm = {{(DATA_W-16){imm16[15]}}, imm16};
        endcase
    end

    // The rt comparison is applied to every opcode, so an instruction that
    // does not actually read rt may stall needlessly; that is harmless.
    assign advance  = !out_valid || ex_ready;
    assign hazard   = out_valid && out_mem_read && (out_wr_reg != REG_AW'(REG_ZERO)) &&
                      ((out_wr_reg == rs_idx) || (out_wr_reg == rt_idx));
    assign in_ready = flush || (advance && !hazard);
    assign capture  = !flush && advance && in_valid && !hazard;
    assign wb_hit   = wb_we && (wb_reg != REG_AW'(REG_ZERO));

    // ID/EX register. Flush wins over everything; a stalled entry keeps its
    // fields but picks up write-backs to its sources, since the regfile
    // bypass only covers instructions still being decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            ctrl_q     <= '0;
            out_rs     <= '0;
            out_rt     <= '0;
            out_wr_reg <= '0;
            out_data_a <= '0;
            out_data_b <= '0;
            out_imm    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            ctrl_q     <= dec_ctrl;
            out_rs     <= rs_idx;
            out_rt     <= rt_idx;
            out_wr_reg <= dec_wr_reg;
            out_data_a <= rs_data;
            out_data_b <= rt_data;
            out_imm    <= dec_imm;
        end else if (advance) begin
            out_valid <= 1'b0;
        end else begin
            if (wb_hit && (wb_reg == out_rs)) begin
                out_data_a <= wb_data;
            end
            if (wb_hit && (wb_reg == out_rt)) begin
                out_data_b <= wb_data;
            end
        end
    end

    assign out_reg_write = ctrl_q.reg_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_illegal   = ctrl_q.illegal;
    assign out_op        = ctrl_q.op;
    assign out_func      = ctrl_q.func;
    assign out_jpc       = ctrl_q.jpc;
    assign out_npc       = ctrl_q.npc;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ins;
    logic [31:0] npc_i;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        out_valid;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_illegal;
    logic [5:0]  out_op;
    logic [5:0]  out_func;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_wr_reg;
    logic [31:0] out_data_a;
    logic [31:0] out_data_b;
    logic [31:0] out_imm;
    logic [25:0] out_jpc;
    logic [31:0] out_npc;

    int checks;
    int failures;

    id_stage_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ins           (ins),
        .npc_i         (npc_i),
        .flush         (flush),
        .wb_we         (wb_we),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .ex_ready      (ex_ready),
        .out_valid     (out_valid),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_illegal   (out_illegal),
        .out_op        (out_op),
        .out_func      (out_func),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_wr_reg    (out_wr_reg),
        .out_data_a    (out_data_a),
        .out_data_b    (out_data_b),
        .out_imm       (out_imm),
        .out_jpc       (out_jpc),
        .out_npc       (out_npc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Drive the ID-side inputs just after a rising edge and let them settle.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] npc, input logic fl, input logic exr);
        in_valid = v;
        ins      = instr;
        npc_i    = npc;
        flush    = fl;
        ex_ready = exr;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ins      = '0;
        npc_i    = '0;
        flush    = 1'b0;
        wb_we    = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        ex_ready = 1'b1;

        #12;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data_a", out_data_a, 32'h0);
        checkOutput("reset_imm", out_imm, 32'h0);
        checkOutput("reset_npc", out_npc, 32'h0);
        rst_n = 1'b1;
        stepClock();

        // ADD r1,r2,r3
        applyStimulus(1'b1, rType(5'd2, 5'd3, 5'd1, 6'h20), 32'h104, 1'b0, 1'b1);
        checkOutput("add_in_ready", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_data_a", out_data_a, 32'h0);
        checkOutput("add_data_b", out_data_b, 32'h0);
        checkOutput("add_wr_reg", 32'(out_wr_reg), 32'd1);
        checkOutput("add_reg_write", 32'(out_reg_write), 32'd1);
        checkOutput("add_rs", 32'(out_rs), 32'd2);
        checkOutput("add_func", 32'(out_func), 32'h20);
        checkOutput("add_npc", out_npc, 32'h104);

        // ADDI r4,r3,5 with WB r3=0x1234 in the same cycle
        applyStimulus(1'b1, iType(6'h08, 5'd3, 5'd4, 16'd5), 32'h108, 1'b0, 1'b1);
        wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'h1234;
        stepClock();
        wb_we = 1'b0;
        checkOutput("addi_bypass_a", out_data_a, 32'h1234);
        checkOutput("addi_imm", out_imm, 32'h5);
        checkOutput("addi_wr_reg", 32'(out_wr_reg), 32'd4);

        // ADD r7,r3,r0 while WB tries to write r0=0xFF
        applyStimulus(1'b1, rType(5'd3, 5'd0, 5'd7, 6'h20), 32'h10C, 1'b0, 1'b1);
        wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hFF;
        stepClock();
        wb_we = 1'b0;
        checkOutput("r3_stored", out_data_a, 32'h1234);
        checkOutput("r0_bypass_zero", out_data_b, 32'h0);

        // ADD r8,r0,r0 after the r0 write attempt
        applyStimulus(1'b1, rType(5'd0, 5'd0, 5'd8, 6'h20), 32'h110, 1'b0, 1'b1);
        stepClock();
        checkOutput("r0_still_zero", out_data_a, 32'h0);

        // LW r4,0(r1) then dependent ADD r5,r4,r6
        applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd4, 16'd0), 32'h114, 1'b0, 1'b1);
        stepClock();
        checkOutput("lw_mem_read", 32'(out_mem_read), 32'd1);
        checkOutput("lw_wr_reg", 32'(out_wr_reg), 32'd4);
        applyStimulus(1'b1, rType(5'd4, 5'd6, 5'd5, 6'h20), 32'h118, 1'b0, 1'b1);
        checkOutput("loaduse_in_ready", 32'(in_ready), 32'd0);
        stepClock();
        checkOutput("loaduse_bubble", 32'(out_valid), 32'd0);
        checkOutput("loaduse_ready_after", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("loaduse_capture_valid", 32'(out_valid), 32'd1);
        checkOutput("loaduse_capture_rs", 32'(out_rs), 32'd4);
        checkOutput("loaduse_capture_wr", 32'(out_wr_reg), 32'd5);

        // Backpressure for 3 cycles with ORI waiting; WB r6=0xBEEF in cycle 2
        applyStimulus(1'b1, iType(6'h0D, 5'd0, 5'd9, 16'h8000), 32'h11C, 1'b0, 1'b0);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        stepClock();
        checkOutput("hold1_rs", 32'(out_rs), 32'd4);
        wb_we = 1'b1; wb_reg = 5'd6; wb_data = 32'hBEEF;
        stepClock();
        wb_we = 1'b0;
        checkOutput("hold2_refresh_b", out_data_b, 32'hBEEF);
        checkOutput("hold2_data_a", out_data_a, 32'h0);
        checkOutput("hold2_wr_reg", 32'(out_wr_reg), 32'd5);
        checkOutput("hold2_npc", out_npc, 32'h118);
        checkOutput("hold2_in_ready", 32'(in_ready), 32'd0);
        stepClock();
        checkOutput("hold3_valid", 32'(out_valid), 32'd1);
        checkOutput("hold3_data_b", out_data_b, 32'hBEEF);
        applyStimulus(1'b1, iType(6'h0D, 5'd0, 5'd9, 16'h8000), 32'h11C, 1'b0, 1'b1);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("ori_valid", 32'(out_valid), 32'd1);
        checkOutput("ori_imm_zext", out_imm, 32'h00008000);
        checkOutput("ori_wr_reg", 32'(out_wr_reg), 32'd9);

        // Flush with backpressure and a valid entry
        applyStimulus(1'b1, iType(6'h08, 5'd0, 5'd10, 16'h8000), 32'h120, 1'b1, 1'b0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        stepClock();
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_no_capture", out_npc, 32'h11C);

        // Immediate extension and decode classes
        applyStimulus(1'b1, iType(6'h08, 5'd0, 5'd10, 16'h8000), 32'h124, 1'b0, 1'b1);
        stepClock();
        checkOutput("addi_imm_sext", out_imm, 32'hFFFF8000);
        applyStimulus(1'b1, iType(6'h0F, 5'd0, 5'd11, 16'h1234), 32'h128, 1'b0, 1'b1);
        stepClock();
        checkOutput("lui_imm", out_imm, 32'h12340000);
        checkOutput("lui_wr_reg", 32'(out_wr_reg), 32'd11);
        applyStimulus(1'b1, iType(6'h2B, 5'd1, 5'd2, 16'd4), 32'h12C, 1'b0, 1'b1);
        stepClock();
        checkOutput("sw_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'h1);
        checkOutput("sw_wr_reg", 32'(out_wr_reg), 32'd0);
        applyStimulus(1'b1, {6'h3F, 26'h0123456}, 32'h130, 1'b0, 1'b1);
        stepClock();
        checkOutput("illegal_flag", 32'(out_illegal), 32'd1);
        checkOutput("illegal_ctrl", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'h0);
        checkOutput("illegal_wr_reg", 32'(out_wr_reg), 32'd0);
        checkOutput("illegal_jpc", 32'(out_jpc), 32'h0123456);
        applyStimulus(1'b1, {6'h03, 26'h0000040}, 32'h134, 1'b0, 1'b1);
        stepClock();
        checkOutput("jal_wr_reg", 32'(out_wr_reg), 32'd31);
        checkOutput("jal_reg_write", 32'(out_reg_write), 32'd1);
        checkOutput("jal_illegal", 32'(out_illegal), 32'd0);

        // No valid input -> bubble
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        stepClock();
        checkOutput("idle_bubble", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 5-stage MIPS pipeline, sitting between the IF/ID and EX stages.
- Contains the architectural register file with WB-to-ID bypass and decodes control signals and immediates.
- Drives a registered ID/EX pipeline register with a valid/ready handshake.
- Adds load-use hazard stall, flush, downstream backpressure, operand refresh while stalled, illegal-opcode flagging and per-class immediate extension.

Parameters:
- DATA_W, 32, register/operand width; must be >= 32.
- REG_NUM, 32, number of architectural registers; power of two, >= 32.
- REG_AW, $clog2(REG_NUM), register index width. Only the low 5 instruction bits are used; upper bits are zero.
- LINK_REG, 31, destination register for JAL.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  ID accepts the instruction this cycle.
- ins  in  32  instruction word.
- npc_i  in  32  PC+4 of the instruction.
- flush  in  1  kill the instruction in ID (branch/jump redirect).
- wb_we  in  1  WB register write enable.
- wb_reg  in  REG_AW  WB destination register.
- wb_data  in  DATA_W  WB write data.
- ex_ready  in  1  EX accepts the ID/EX contents.
- out_valid  out  1  ID/EX holds a valid instruction.
- out_reg_write, out_mem_read, out_mem_write  out  1 each  control signals.
- out_illegal  out  1  unknown opcode.
- out_op, out_func  out  6 each  ins[31:26], ins[5:0].
- out_rs, out_rt, out_wr_reg  out  REG_AW each  source and destination indices.
- out_data_a, out_data_b  out  DATA_W each  operands (rs, rt).
- out_imm  out  DATA_W  extended immediate.
- out_jpc  out  26  ins[25:0].
- out_npc  out  32  npc_i passed through.

Behaviour:
- Reset (rst_n low, asynchronous): all ID/EX outputs are 0, out_valid=0, and all REG_NUM registers are cleared to 0.
- Register file:
  - Write on the rising edge when wb_we and wb_reg != 0.
  - Register 0 always reads 0.
- Read bypass (combinational): if wb_we && wb_reg == index && index != 0, the read returns wb_data; otherwise it returns the array value.
- Decode (per instruction class):
  - R-type (op 000000): reg_write=1, wr_reg=rd.
  - ADDI/ADDIU/ANDI/ORI/XORI/LUI: reg_write=1, wr_reg=rt.
  - LW/LB: reg_write=1, mem_read=1, wr_reg=rt.
  - SW/SB: mem_write=1.
  - BEQ/BNE/BGTZ/J: no writes.
  - JAL: reg_write=1, wr_reg=LINK_REG.
  - Any other opcode: all controls 0, illegal=1.
  - Where a class has no destination, wr_reg=0.
- Immediate extension:
  - ANDI/ORI/XORI: zero-extend to DATA_W.
  - LUI: {imm16, 16'b0}, zero-extended to DATA_W.
  - All other opcodes: sign-extend to DATA_W.
- Handshake signals:
  - advance = !out_valid || ex_ready.
  - hazard = out_valid && out_mem_read && out_wr_reg != 0 && (out_wr_reg == rs || out_wr_reg == rt).
  - The rt comparison applies to every opcode; a false stall is acceptable.
  - in_ready = flush || (advance && !hazard).
- ID/EX register update, evaluated in priority order on each edge:
  1. flush: out_valid <= 0 and the incoming instruction is consumed and discarded. Flush overrides hazard and backpressure.
  2. advance && in_valid && !hazard: capture the decoded instruction, out_valid <= 1.
  3. advance (hazard or !in_valid): insert a bubble, out_valid <= 0, other fields don't-care.
  4. !advance: hold all fields.
- Operand refresh during hold: if wb_we && wb_reg != 0 matches out_rs (or out_rt), out_data_a (or out_data_b) <= wb_data. Both may update on the same edge.
- Load-use latency: exactly one bubble when ex_ready=1; more while EX backpressures.
- Latency: an accepted instruction appears on outputs the cycle after acceptance.

Decomposition:
- Shared package mips_pkg:
  - opcode localparams (OP_SPECIAL, OP_ADDI, ..., OP_JAL).
  - REG_ZERO.
  - Struct id_ex_t bundling the ID/EX fields.
  - Extension-kind enum: SIGN, ZERO, UPPER.
- Sub-module regfile:
  - Parameters DATA_W and REG_NUM.
  - Two read ports with WB bypass, one write port, async-reset array.
  - Decode, hazard logic and the pipeline register stay in id_stage_pipe.

Test Plan:
- Reset then release; instruction ADD r1,r2,r3 → out_valid=1 next cycle, out_data_a=out_data_b=0, out_wr_reg=1, out_reg_write=1.
- Same cycle: wb_we=1, wb_reg=3, wb_data=0x1234, and ADDI r4,r3,5 in ID → out_data_a=0x1234; a later read of r3 returns 0x1234. wb_reg=0 with data 0xFF leaves r0 at 0.
- LW r4,0(r1) accepted, then ADD r5,r4,r6 presented with ex_ready=1 → in_ready=0 for 1 cycle, bubble (out_valid=0), then ADD captured with out_rs=4.
- ex_ready=0 for 3 cycles with ADD r5,r4,r6 held; WB writes r6=0xBEEF in cycle 2 → out_data_b=0xBEEF, all other fields unchanged, in_ready=0; ex_ready=1 → next instruction accepted.
- flush=1 with in_valid=1, ex_ready=0, out_valid=1 → in_ready=1, out_valid=0 next cycle, no instruction captured.
- Immediate 0x8000 cases: ORI → 0x00008000; ADDI → 0xFFFF8000; LUI 0x1234 → 0x12340000. Opcode 111111 → out_illegal=1, all controls 0.
